// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control producer: decodes ALUOp/funct into the 4-bit ALU control code,
// runs MUL as an iterative shift-add sequence while stalling the pipeline, and
// presents the low 32 bits of the product on a dedicated result port.
module alu_ctrl_seq #(
    parameter int unsigned RADIX_BITS = 1   // multiplier bits retired per cycle: 1, 2 or 4
) (
    input  logic        clk_i,
    input  logic        rst_i,        // asynchronous, active-low
    input  logic        valid_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [3:0]  ALUCtrl_o,
    output logic        stall_o,
    output logic        mul_valid_o,
    output logic [31:0] mul_data_o,
    output logic        err_o
);

    localparam int unsigned N     = 32 / RADIX_BITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_MUL = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [31:0]      mplier_q, mplier_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       dec_ctrl;
    logic             dec_mul;
    logic             dec_undef;
    logic [31:0]      pp_sum;

    // Combinational instruction decode of the ID/EX fields.
    always_comb begin
        dec_ctrl  = CTRL_ADD;
        dec_mul   = 1'b0;
        dec_undef = 1'b0;
        unique case (ALUOp_i)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b11: dec_ctrl = CTRL_ADD;
            default: begin
                unique case (funct_i)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b011000: begin
                        dec_ctrl = CTRL_MUL;
                        dec_mul  = 1'b1;
                    end
                    default: begin
                        dec_ctrl  = CTRL_ADD;
                        dec_undef = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Sum of the partial products selected by the low RADIX_BITS multiplier bits.
    always_comb begin
        pp_sum = '0;
        for (int unsigned j = 0; j < RADIX_BITS; j++) begin
            if (mplier_q[j]) begin
                pp_sum = pp_sum + (mcand_q << j);
            end
        end
    end

    // Next-state, datapath update and output generation.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        ALUCtrl_o   = dec_ctrl;
        stall_o     = 1'b0;
        mul_valid_o = 1'b0;
        err_o       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                err_o = valid_i & dec_undef;
                if (valid_i && dec_mul) begin
                    stall_o  = 1'b1;
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                ALUCtrl_o = CTRL_MUL;
                stall_o   = 1'b1;
                acc_d     = acc_q + pp_sum;
                mcand_d   = mcand_q << RADIX_BITS;
                mplier_d  = mplier_q >> RADIX_BITS;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Latch the final sum here so the product survives the next accept,
                    // which clears the accumulator.
                    res_d   = acc_q + pp_sum;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The held mul in ID/EX is ignored; returning to IDLE unconditionally
                // prevents a second accept of the same instruction.
                ALUCtrl_o   = CTRL_MUL;
                mul_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held the FSM is pinned in IDLE; keep the pipeline moving.
        if (!rst_i) begin
            stall_o = 1'b0;
            err_o   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mul_data_o = res_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, error pulse, multi-cycle MUL timing
// and results, back-to-back muls, reset abort, and a radix-4 instance.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0;
    logic        v4 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [5:0]  fn = 6'b000000;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;

    logic [3:0]  ctl1, ctl4;
    logic        st1, st4, mv1, mv4, er1, er4;
    logic [31:0] md1, md4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_pulse = 0;

    localparam logic [5:0] F_MUL = 6'b011000;

    alu_ctrl_seq #(.RADIX_BITS(1)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v1), .ALUOp_i(op), .funct_i(fn),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_o(ctl1), .stall_o(st1),
        .mul_valid_o(mv1), .mul_data_o(md1), .err_o(er1)
    );

    alu_ctrl_seq #(.RADIX_BITS(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v4), .ALUOp_i(op), .funct_i(fn),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_o(ctl4), .stall_o(st4),
        .mul_valid_o(mv4), .mul_data_o(md4), .err_o(er4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Start at posedge+1; returns at posedge+1 of the cycle after the pulse.
    task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit hold, input string tag);
        int stalls = 0;
        int pre = 0;
        bit seen = 1'b0;
        int exp_st = sel ? 9 : 33;
        logic st, mv;
        logic [3:0] ct;
        logic [31:0] md;
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        op = 2'b10; fn = F_MUL; d1 = a; d2 = b;
        for (int c = 0; c < 80 && !seen; c++) begin
            #2;
            st = sel ? st4 : st1;
            mv = sel ? mv4 : mv1;
            md = sel ? md4 : md1;
            ct = sel ? ctl4 : ctl1;
            if (mv) begin
                seen = 1'b1;
                last_pulse = cyc;
                chk({tag, "_pulse_stall"}, {31'b0, st}, 32'd0);
                chk({tag, "_data"}, md, exp);
                chk({tag, "_ctl"}, {28'b0, ct}, 32'h4);
            end else begin
                if (st) stalls++;
                pre++;
            end
            @(posedge clk); #1;
        end
        if (!hold) begin v1 = 1'b0; v4 = 1'b0; end
        chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_stalls"}, stalls, exp_st);
        chk({tag, "_latency"}, pre, exp_st);
    endtask

    localparam logic [1:0] T_OP  [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
    localparam logic [5:0] T_FN  [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b000011, 6'b000011, 6'b000011, 6'b011000, 6'b100000};
    localparam logic [3:0] T_EXP [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                         4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0010};

    initial begin
        int p1, p2, pulses;

        // Reset state; decode still live and mul not accepted under reset.
        #3;
        op = 2'b01; fn = 6'b000000;
        #1;
        chk("rst_stall", {31'b0, st1}, 32'd0);
        chk("rst_mv", {31'b0, mv1}, 32'd0);
        chk("rst_md", md1, 32'd0);
        chk("rst_err", {31'b0, er1}, 32'd0);
        chk("rst_ctl_sub", {28'b0, ctl1}, 32'h6);
        v1 = 1'b1; op = 2'b10; fn = F_MUL;
        #1;
        chk("rst_mul_stall", {31'b0, st1}, 32'd0);
        chk("rst_mul_ctl", {28'b0, ctl1}, 32'h4);
        op = 2'b10; fn = 6'b000011;
        #1;
        chk("rst_undef_err", {31'b0, er1}, 32'd0);
        v1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode table with valid asserted.
        for (int i = 0; i < 9; i++) begin
            v1 = 1'b1; op = T_OP[i]; fn = T_FN[i];
            #2;
            chk($sformatf("dec%0d_ctl", i), {28'b0, ctl1}, {28'b0, T_EXP[i]});
            chk($sformatf("dec%0d_stall", i), {31'b0, st1}, 32'd0);
            chk($sformatf("dec%0d_err", i), {31'b0, er1}, 32'd0);
            @(posedge clk); #1;
        end

        // Mul decoded without valid: control code shown, no stall.
        v1 = 1'b0; op = 2'b10; fn = F_MUL;
        #2;
        chk("mulnv_ctl", {28'b0, ctl1}, 32'h4);
        chk("mulnv_stall", {31'b0, st1}, 32'd0);
        @(posedge clk); #1;

        // Undefined funct.
        v1 = 1'b1; op = 2'b10; fn = 6'b000011;
        #2;
        chk("undef_err", {31'b0, er1}, 32'd1);
        chk("undef_ctl", {28'b0, ctl1}, 32'h2);
        chk("undef_stall", {31'b0, st1}, 32'd0);
        v1 = 1'b0;
        #1;
        chk("undef_nv_err", {31'b0, er1}, 32'd0);
        @(posedge clk); #1;

        // 7 x 6, then result holds and no duplicate pulse.
        run_mul(1'b0, 32'd7, 32'd6, 32'd42, 1'b0, "m7x6");
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("hold%0d_mv", i), {31'b0, mv1}, 32'd0);
            chk($sformatf("hold%0d_md", i), md1, 32'd42);
            @(posedge clk); #1;
        end

        run_mul(1'b0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, "mffx3");
        run_mul(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, "m64k");
        run_mul(1'b0, 32'd0, 32'h1234, 32'h0, 1'b0, "m0");
        run_mul(1'b0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "m3xff");

        // Back-to-back: second mul enters ID/EX right after DONE.
        run_mul(1'b0, 32'd3, 32'd5, 32'd15, 1'b1, "bb1");
        p1 = last_pulse;
        run_mul(1'b0, 32'h8000_0000, 32'd2, 32'h0, 1'b0, "bb2");
        p2 = last_pulse;
        chk("bb_spacing", p2 - p1, 32'd34);

        // Reset during MUL cycle 10 abandons the multiply.
        v1 = 1'b1; op = 2'b10; fn = F_MUL; d1 = 32'd7; d2 = 32'd6;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_pre_stall", {31'b0, st1}, 32'd1);
        rst_n = 1'b0; v1 = 1'b0;
        #1;
        chk("abort_stall", {31'b0, st1}, 32'd0);
        chk("abort_mv", {31'b0, mv1}, 32'd0);
        chk("abort_md", md1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (mv1 || st1) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", pulses, 32'd0);
        run_mul(1'b0, 32'd2, 32'd9, 32'd18, 1'b0, "m2x9");

        // Radix-4 instance.
        run_mul(1'b1, 32'd7, 32'd6, 32'd42, 1'b0, "r4_7x6");
        run_mul(1'b1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, "r4_ffx3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
